// File: rtl/yuv_frame_ctrl_pkg.sv
// Shared types and constants for the frame sequencer and its timing counter.
// Latency: n/a (declarations only).
// Backpressure: n/a; the raster runs free at one pixel per clock.
package yuv_pkg;

    // Counter width; covers both the 800-clock line and the 525-line frame
    localparam int CNT_W = 10;

    // Colour-space converter latency, used by downstream alignment logic
    localparam int CONV_LAT = 3;

    typedef enum logic [1:0] {
        MODE_RGB = 2'd0,
        MODE_Y   = 2'd1,
        MODE_U   = 2'd2,
        MODE_V   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } state_e;

    // Timing word carried down the fetch-alignment delay line (syncs active-high)
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } tim_t;

    localparam tim_t TIM_IDLE = '{hs: 1'b0, vs: 1'b0, blank: 1'b1};

    // True when lo <= val < hi
    function automatic logic in_win(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/yuv_frame_ctrl_if.sv
// Bundle of the sequencer's control inputs and raster/status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; o_pix_req is a free-running strobe the frame buffer must accept.
interface yuv_frame_ctrl_if;
    logic       i_enable;
    logic [1:0] i_mode_sel;
    logic       o_pix_req;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       o_HSYNC;
    logic       o_VSYNC;
    logic       o_BLANK;
    logic [1:0] o_mode;
    logic       o_mode_upd;
    logic       o_frame_start;
    logic       o_busy;

    // Sequencer side
    modport master (
        input  i_enable, i_mode_sel,
        output o_pix_req, o_x, o_y, o_HSYNC, o_VSYNC, o_BLANK,
        output o_mode, o_mode_upd, o_frame_start, o_busy
    );

    // Environment side
    modport slave (
        output i_enable, i_mode_sel,
        input  o_pix_req, o_x, o_y, o_HSYNC, o_VSYNC, o_BLANK,
        input  o_mode, o_mode_upd, o_frame_start, o_busy
    );
endinterface

// File: rtl/yuv_frame_ctrl_timing.sv
// Horizontal/vertical raster counters with combinational sync/active decode.
// Latency: decode is combinational from the current counter values.
// Backpressure: none; counters advance every clock while cnt_en_i is high.
module vid_timing_cnt
    import yuv_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en_i,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [8:0]       row_o,
    output logic             last_o,
    output logic             active_o,
    output logic             hsync_o,
    output logic             vsync_o
);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             h_last;

    assign h_last = (h_q == H_LAST);

    // Next counter values: h wraps into a v increment, v wraps at frame end
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (cnt_en_i) begin
            if (h_last) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt_o  = h_q;
    assign row_o    = v_q[8:0];
    assign last_o   = h_last && (v_q == V_LAST);
    assign active_o = (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_o  = in_win(h_q, HS_BEG, HS_END);
    assign vsync_o  = in_win(v_q, VS_BEG, VS_END);

endmodule

// File: rtl/yuv_frame_ctrl.sv
// Frame sequencer: run/stop FSM, pixel fetch requests, fetch-aligned syncs, frame-boundary mode latch.
// Latency: o_pix_req 1 clock after the counter position; syncs/blank a further FETCH_LAT clocks.
// Backpressure: none; fetches are issued one per clock and the frame buffer must keep up.
module yuv_frame_ctrl
    import yuv_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0,
    parameter int FETCH_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    yuv_frame_ctrl_if.master bus
);
    localparam logic SYNC_ACT = 1'(SYNC_POL);

    state_e           state_q, state_d;
    logic             running;
    logic [CNT_W-1:0] h_cnt;
    logic [8:0]       row;
    logic             last, active, hsync, vsync;

    logic             frame_start_d, frame_start_q;
    logic             pix_req_d, pix_req_q;
    logic [9:0]       x_d, x_q;
    logic [8:0]       y_d, y_q;
    mode_e            mode_d, mode_q;
    logic             mode_upd_d, mode_upd_q;
    tim_t             tim_d;
    tim_t             dly_q [FETCH_LAT+1];

    assign running = (state_q != ST_IDLE);

    vid_timing_cnt #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .cnt_en_i (running),
        .h_cnt_o  (h_cnt),
        .row_o    (row),
        .last_o   (last),
        .active_o (active),
        .hsync_o  (hsync),
        .vsync_o  (vsync)
    );

    // Run/stop sequencing; a stop request only takes effect at a frame boundary
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (bus.i_enable) state_d = ST_RUN;
            ST_RUN:       if (!bus.i_enable) state_d = ST_STOP_PEND;
            ST_STOP_PEND: begin
                if (bus.i_enable)  state_d = ST_RUN;
                else if (last)     state_d = ST_IDLE;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    // Next values of all registered raster outputs and the mode latch
    always_comb begin
        frame_start_d = (state_q == ST_IDLE && bus.i_enable) ||
                        (running && last && state_d != ST_IDLE);
        pix_req_d     = running && active;
        x_d           = x_q;
        y_d           = y_q;
        if (pix_req_d) begin
            x_d = h_cnt;
            y_d = row;
        end
        tim_d = TIM_IDLE;
        if (running) begin
            tim_d = '{hs: hsync, vs: vsync, blank: ~active};
        end
        mode_d     = mode_q;
        mode_upd_d = 1'b0;
        if (running && last) begin
            mode_d     = mode_e'(bus.i_mode_sel);
            mode_upd_d = (bus.i_mode_sel != mode_q);
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            frame_start_q <= 1'b0;
            pix_req_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            mode_q        <= MODE_RGB;
            mode_upd_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_start_q <= frame_start_d;
            pix_req_q     <= pix_req_d;
            x_q           <= x_d;
            y_q           <= y_d;
            mode_q        <= mode_d;
            mode_upd_q    <= mode_upd_d;
        end
    end

    // Stage 0 aligns timing with o_pix_req; FETCH_LAT more stages match the read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= FETCH_LAT; i++) dly_q[i] <= TIM_IDLE;
        end else begin
            dly_q[0] <= tim_d;
            for (int i = 1; i <= FETCH_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign bus.o_pix_req     = pix_req_q;
    assign bus.o_x           = x_q;
    assign bus.o_y           = y_q;
    assign bus.o_HSYNC       = dly_q[FETCH_LAT].hs ? SYNC_ACT : ~SYNC_ACT;
    assign bus.o_VSYNC       = dly_q[FETCH_LAT].vs ? SYNC_ACT : ~SYNC_ACT;
    assign bus.o_BLANK       = dly_q[FETCH_LAT].blank;
    assign bus.o_mode        = mode_q;
    assign bus.o_mode_upd    = mode_upd_q;
    assign bus.o_frame_start = frame_start_q;
    assign bus.o_busy        = running;

endmodule

// File: tb/tb_yuv_frame_ctrl.sv
// Scoreboard bench for yuv_frame_ctrl on a reduced raster (15 x 8 clocks per frame).
// Latency: expected event times derived from counter position + 1 (+FETCH_LAT for timing).
// Backpressure: n/a.
module tb_yuv_frame_ctrl;
    localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2;
    localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
    localparam int FL = 2;
    localparam int HT = HA + HFP + HSW + HBP;   // 15
    localparam int VT = VA + VFP + VSW + VBP;   // 8
    localparam int FR = HT * VT;                // 120
    localparam int BIG = 1 << 30;

    typedef struct { int cyc; int a; int b; } ev_t;
    typedef struct {
        int cyc; logic pix; int x; int y; logic hs; logic vs; logic bl; int mode; logic busy;
    } snap_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   s0, s2, s3;

    ev_t   q_pix[$], q_fs[$], q_bl[$], q_hs[$], q_vs[$], q_upd[$], q_busy[$];
    snap_t q_snap[$];

    yuv_frame_ctrl_if bus();

    yuv_frame_ctrl #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .SYNC_POL (0), .FETCH_LAT (FL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input int a, input int b);
        ev_t e;
        e.cyc = c; e.a = a; e.b = b;
        return e;
    endfunction

    task automatic snap(input int c, input logic pix, input int x, input int y, input logic hs,
                        input logic vs, input logic bl, input int mode, input logic busy);
        snap_t s;
        s.cyc = c; s.pix = pix; s.x = x; s.y = y; s.hs = hs; s.vs = vs; s.bl = bl;
        s.mode = mode; s.busy = busy;
        q_snap.push_back(s);
    endtask

    // Expected events of one frame whose first RUN cycle is s, up to (excluding) cycle lim
    task automatic push_frame(input int s, input int lim);
        int c;
        if (s < lim) q_fs.push_back(mk(s, 0, 0));
        for (int v = 0; v < VT; v++) begin
            if (v < VA) begin
                for (int h = 0; h < HA; h++) begin
                    c = s + v * HT + h + 1;
                    if (c < lim) q_pix.push_back(mk(c, h, v));
                end
                c = s + 1 + FL + v * HT;
                if (c < lim) q_bl.push_back(mk(c, 0, 0));
            end
            c = s + 1 + FL + v * HT + HA + HFP;
            if (c < lim) q_hs.push_back(mk(c, 0, 0));
        end
        c = s + 1 + FL + (VA + VFP) * HT;
        if (c < lim) q_vs.push_back(mk(c, 0, 0));
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input ev_t e, input int c, input int a, input int b);
        n_tests++;
        if (e.cyc != c || e.a != a || e.b != b) begin
            n_fail++;
            $display("FAIL %s: got cyc=%0d a=%0d b=%0d, expected cyc=%0d a=%0d b=%0d",
                     nm, c, a, b, e.cyc, e.a, e.b);
        end
    endtask

    task automatic unexpected(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event at cyc=%0d, none expected", nm, cyc);
    endtask

    task automatic leftover(input string nm, input int n);
        n_tests++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events never seen, required 0", nm, n);
        end
    endtask

    // Monitor: samples on the falling edge, pops expected events when the DUT presents them
    initial begin
        ev_t   e;
        snap_t s;
        logic  p_bl, p_hs, p_vs, p_busy;
        p_bl = 1'b1; p_hs = 1'b1; p_vs = 1'b1; p_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_pix_req) begin
                if (q_pix.size() == 0) unexpected("pix");
                else begin e = q_pix.pop_front(); chk("pix", e, cyc, int'(bus.o_x), int'(bus.o_y)); end
            end
            if (bus.o_frame_start) begin
                if (q_fs.size() == 0) unexpected("frame_start");
                else begin e = q_fs.pop_front(); chk("frame_start", e, cyc, 0, 0); end
            end
            if (bus.o_mode_upd) begin
                if (q_upd.size() == 0) unexpected("mode_upd");
                else begin e = q_upd.pop_front(); chk("mode_upd", e, cyc, int'(bus.o_mode), 0); end
            end
            if (p_bl && !bus.o_BLANK) begin
                if (q_bl.size() == 0) unexpected("blank_fall");
                else begin e = q_bl.pop_front(); chk("blank_fall", e, cyc, 0, 0); end
            end
            if (p_hs && !bus.o_HSYNC) begin
                if (q_hs.size() == 0) unexpected("hsync_fall");
                else begin e = q_hs.pop_front(); chk("hsync_fall", e, cyc, 0, 0); end
            end
            if (p_vs && !bus.o_VSYNC) begin
                if (q_vs.size() == 0) unexpected("vsync_fall");
                else begin e = q_vs.pop_front(); chk("vsync_fall", e, cyc, 0, 0); end
            end
            if (p_busy && !bus.o_busy) begin
                if (q_busy.size() == 0) unexpected("busy_fall");
                else begin e = q_busy.pop_front(); chk("busy_fall", e, cyc, 0, 0); end
            end
            while (q_snap.size() > 0 && q_snap[0].cyc <= cyc) begin
                s = q_snap.pop_front();
                n_tests++;
                if (s.cyc != cyc || s.pix !== bus.o_pix_req || s.x != int'(bus.o_x) ||
                    s.y != int'(bus.o_y) || s.hs !== bus.o_HSYNC || s.vs !== bus.o_VSYNC ||
                    s.bl !== bus.o_BLANK || s.mode != int'(bus.o_mode) || s.busy !== bus.o_busy) begin
                    n_fail++;
                    $display("FAIL snap@%0d (cyc %0d): got pix=%0b x=%0d y=%0d hs=%0b vs=%0b bl=%0b mode=%0d busy=%0b, expected pix=%0b x=%0d y=%0d hs=%0b vs=%0b bl=%0b mode=%0d busy=%0b",
                             s.cyc, cyc, bus.o_pix_req, bus.o_x, bus.o_y, bus.o_HSYNC, bus.o_VSYNC,
                             bus.o_BLANK, bus.o_mode, bus.o_busy,
                             s.pix, s.x, s.y, s.hs, s.vs, s.bl, s.mode, s.busy);
                end
            end
            p_bl = bus.o_BLANK; p_hs = bus.o_HSYNC; p_vs = bus.o_VSYNC; p_busy = bus.o_busy;
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1;
        bus.i_enable = 1'b0;
        bus.i_mode_sel = 2'd0;
        snap(2, 0, 0, 0, 1, 1, 1, 0, 0);
        wait_cyc(3);
        rst = 1'b0;

        // Three frames: mode change, stop/restart inside a frame, stop on the last cycle
        s0 = 6;
        snap(s0,       0, 0, 0, 1, 1, 1, 0, 1);
        snap(s0 + 1,   1, 0, 0, 1, 1, 1, 0, 1);
        snap(s0 + 2,   1, 1, 0, 1, 1, 1, 0, 1);
        snap(s0 + 3,   1, 2, 0, 1, 1, 0, 0, 1);
        snap(s0 + 15,  0, 7, 0, 0, 1, 1, 0, 1);
        snap(s0 + 16,  1, 0, 1, 1, 1, 1, 0, 1);
        snap(s0 + 107, 0, 7, 3, 1, 0, 1, 0, 1);
        snap(s0 + 108, 0, 7, 3, 1, 1, 1, 0, 1);
        snap(s0 + 119, 0, 7, 3, 0, 1, 1, 0, 1);
        snap(s0 + 120, 0, 7, 3, 0, 1, 1, 1, 1);
        snap(s0 + 365, 0, 7, 3, 1, 1, 1, 2, 0);
        push_frame(s0, BIG);
        push_frame(s0 + FR, BIG);
        push_frame(s0 + 2 * FR, BIG);
        q_upd.push_back(mk(s0 + FR, 1, 0));
        q_upd.push_back(mk(s0 + 3 * FR, 2, 0));
        q_busy.push_back(mk(s0 + 3 * FR, 0, 0));

        wait_cyc(s0 - 1);
        bus.i_enable = 1'b1;
        wait_cyc(s0 + 2 * HT);
        bus.i_mode_sel = 2'd1;
        wait_cyc(s0 + FR + HT);
        bus.i_enable = 1'b0;
        wait_cyc(s0 + FR + 2 * HT);
        bus.i_enable = 1'b1;
        wait_cyc(s0 + 2 * FR - 1);
        bus.i_enable = 1'b0;
        wait_cyc(s0 + 2 * FR + 10);
        bus.i_mode_sel = 2'd2;

        // Restart, then reset at counter (4,2) mid-frame
        wait_cyc(s0 + 370);
        s2 = s0 + 371;
        push_frame(s2, s2 + 2 * HT + 4);
        q_busy.push_back(mk(s2 + 2 * HT + 4, 0, 0));
        snap(s2 + 2 * HT + 4, 0, 0, 0, 1, 1, 1, 0, 0);
        bus.i_enable = 1'b1;
        wait_cyc(s2 + 2 * HT + 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.i_mode_sel = 2'd3;

        // Release with enable held: raster restarts from (0,0)
        wait_cyc(s2 + 2 * HT + 6);
        s3 = cyc + 1;
        push_frame(s3, BIG);
        q_upd.push_back(mk(s3 + FR, 3, 0));
        q_busy.push_back(mk(s3 + FR, 0, 0));
        snap(s3,     0, 0, 0, 1, 1, 1, 0, 1);
        snap(s3 + 1, 1, 0, 0, 1, 1, 1, 0, 1);
        rst = 1'b0;
        wait_cyc(s3 + 60);
        bus.i_enable = 1'b0;
        wait_cyc(s3 + FR + 6);

        leftover("pix", q_pix.size());
        leftover("frame_start", q_fs.size());
        leftover("blank_fall", q_bl.size());
        leftover("hsync_fall", q_hs.size());
        leftover("vsync_fall", q_vs.size());
        leftover("mode_upd", q_upd.size());
        leftover("busy_fall", q_busy.size());
        leftover("snap", q_snap.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
